// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: assembles {HDR,fun},A,B frames, drives the ALU, returns the 16-bit result low byte first.
// Optional ALU_TIMEOUT_EN macro adds a bounded ALU_WAIT with a one-cycle ALU_ERR pulse on expiry.
module alu_cmd_ctrl #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          RESULT_WIDTH   = 16,
  parameter logic [3:0]  HDR            = 4'hC,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  input  logic [RESULT_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    ALU_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    ALU_WAIT = 3'd3,
    SEND_LO  = 3'd4,
    SEND_HI  = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   a_r, a_s;
  logic [DATA_WIDTH-1:0]   b_r, b_s;
  logic [3:0]              fun_r, fun_s;
  logic                    en_r, en_s;
  logic [RESULT_WIDTH-1:0] result_r, result_s;
  logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_s;
  logic                    tx_valid_r, tx_valid_s;
  logic                    busy_r, busy_s;
  logic                    err_r, err_s;

`ifdef ALU_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] cnt_r, cnt_s;
`endif

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      fun_r      <= 4'h0;
      en_r       <= 1'b0;
      result_r   <= '0;
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      a_r        <= a_s;
      b_r        <= b_s;
      fun_r      <= fun_s;
      en_r       <= en_s;
      result_r   <= result_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

`ifdef ALU_TIMEOUT_EN
  // ALU_WAIT cycle counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= 4'h0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    fun_s      = fun_r;
    en_s       = en_r;
    result_s   = result_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    err_s      = 1'b0;
`ifdef ALU_TIMEOUT_EN
    cnt_s      = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (RX_VALID && (RX_DATA[DATA_WIDTH-1:DATA_WIDTH-4] == HDR)) begin
          fun_s   = RX_DATA[3:0];
          state_s = GET_A;
        end else begin
          state_s = IDLE;
        end
      end
      GET_A: begin
        if (RX_VALID) begin
          a_s     = RX_DATA;
          state_s = GET_B;
        end else begin
          state_s = GET_A;
        end
      end
      GET_B: begin
        if (RX_VALID) begin
          b_s     = RX_DATA;
          en_s    = 1'b1;
          state_s = ALU_WAIT;
`ifdef ALU_TIMEOUT_EN
          cnt_s   = 4'h0;
`endif
        end else begin
          state_s = GET_B;
        end
      end
      ALU_WAIT: begin
        en_s = 1'b1;
        // OUT_VALID takes priority over an expiring timeout on the same edge
        if (OUT_VALID) begin
          result_s   = ALU_OUT;
          en_s       = 1'b0;
          tx_data_s  = ALU_OUT[DATA_WIDTH-1:0];
          tx_valid_s = 1'b1;
          state_s    = SEND_LO;
        end else begin
`ifdef ALU_TIMEOUT_EN
          if (cnt_r == TO_LAST) begin
            en_s    = 1'b0;
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            cnt_s   = cnt_r + 4'd1;
          end
`else
          state_s = ALU_WAIT;
`endif
        end
      end
      SEND_LO: begin
        tx_valid_s = 1'b1;
        if (TX_READY) begin
          tx_data_s = result_r[RESULT_WIDTH-1:DATA_WIDTH];
          state_s   = SEND_HI;
        end else begin
          state_s   = SEND_LO;
        end
      end
      SEND_HI: begin
        tx_valid_s = 1'b1;
        if (TX_READY) begin
          tx_valid_s = 1'b0;
          state_s    = IDLE;
        end else begin
          state_s    = SEND_HI;
        end
      end
      default: begin
        state_s    = IDLE;
        en_s       = 1'b0;
        tx_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s == ALU_WAIT) || (state_s == SEND_LO) || (state_s == SEND_HI);
  end

  assign ALU_A    = a_r;
  assign ALU_B    = b_r;
  assign ALU_FUN  = fun_r;
  assign ALU_EN   = en_r;
  assign TX_DATA  = tx_data_r;
  assign TX_VALID = tx_valid_r;
  assign BUSY     = busy_r;
`ifdef ALU_TIMEOUT_EN
  assign ALU_ERR  = err_r;
`else
  assign ALU_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU stand-in; expected bytes are hand-computed.
module tb_alu_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        ALU_ERR;

  logic        alu_auto;
  int          passed;
  int          failed;
  int          total;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .ALU_ERR(ALU_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU stand-in: answers one cycle after it sees ALU_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT   <= 16'h0000;
    end else if (alu_auto && ALU_EN) begin
      OUT_VALID <= 1'b1;
      case (ALU_FUN)
        4'h0:    ALU_OUT <= {8'h00, ALU_A} + {8'h00, ALU_B};
        4'h2:    ALU_OUT <= {8'h00, ALU_A} * {8'h00, ALU_B};
        4'h4:    ALU_OUT <= {8'h00, ALU_A & ALU_B};
        default: ALU_OUT <= 16'h0000;
      endcase
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  // Wait (bounded) for TX_VALID, check the byte, let it be accepted with TX_READY high
  task automatic expect_tx(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (TX_VALID !== 1'b1 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_valid"}, {15'd0, TX_VALID}, 16'h0001);
    check(tag, {8'h00, TX_DATA}, {8'h00, exp});
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0; failed = 0; total = 0;
    alu_auto = 1'b1;
    RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b1;
    RST = 1'b1;
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_a", {8'h00, ALU_A}, 16'h0000);
    check("rst_b", {8'h00, ALU_B}, 16'h0000);
    check("rst_fun", {12'h000, ALU_FUN}, 16'h0000);
    check("rst_en", {15'd0, ALU_EN}, 16'h0000);
    check("rst_txd", {8'h00, TX_DATA}, 16'h0000);
    check("rst_txv", {15'd0, TX_VALID}, 16'h0000);
    check("rst_busy", {15'd0, BUSY}, 16'h0000);
    check("rst_err", {15'd0, ALU_ERR}, 16'h0000);
    RST = 1'b1;
    @(negedge CLK);

    // Add: exact latency from the byte2 accept edge
    send_byte(8'hC0);
    send_byte(8'h12);
    send_byte(8'h34);
    check("add_en_e0", {15'd0, ALU_EN}, 16'h0001);
    check("add_fun", {12'h000, ALU_FUN}, 16'h0000);
    check("add_a", {8'h00, ALU_A}, 16'h0012);
    check("add_b", {8'h00, ALU_B}, 16'h0034);
    check("add_busy", {15'd0, BUSY}, 16'h0001);
    check("add_txv_e0", {15'd0, TX_VALID}, 16'h0000);
    @(negedge CLK);
    check("add_txv_e1", {15'd0, TX_VALID}, 16'h0000);
    @(negedge CLK);
    check("add_txv_e2", {15'd0, TX_VALID}, 16'h0001);
    check("add_lo", {8'h00, TX_DATA}, 16'h0046);
    check("add_en_e2", {15'd0, ALU_EN}, 16'h0000);
    @(negedge CLK);
    check("add_txv_e3", {15'd0, TX_VALID}, 16'h0001);
    check("add_hi", {8'h00, TX_DATA}, 16'h0000);
    @(negedge CLK);
    check("add_txv_e4", {15'd0, TX_VALID}, 16'h0000);
    check("add_busy_e4", {15'd0, BUSY}, 16'h0000);

    // Multiply, with a header-like byte landing in ALU_WAIT right after byte2
    send_byte(8'hC2);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hC5);
    expect_tx(8'h01, "mul_lo");
    expect_tx(8'hFE, "mul_hi");
    check("mul_busy", {15'd0, BUSY}, 16'h0000);
    check("mul_txv", {15'd0, TX_VALID}, 16'h0000);
    check("mul_fun_stable", {12'h000, ALU_FUN}, 16'h0002);

    // Bad header dropped; new header straight after the previous handshake
    send_byte(8'h5A);
    check("bad_en0", {15'd0, ALU_EN}, 16'h0000);
    check("bad_busy", {15'd0, BUSY}, 16'h0000);
    send_byte(8'hC0);
    check("bad_en1", {15'd0, ALU_EN}, 16'h0000);
    send_byte(8'h01);
    check("bad_en2", {15'd0, ALU_EN}, 16'h0000);
    send_byte(8'h02);
    check("bad_en3", {15'd0, ALU_EN}, 16'h0001);
    check("bad_fun", {12'h000, ALU_FUN}, 16'h0000);
    expect_tx(8'h03, "bad_lo");
    expect_tx(8'h00, "bad_hi");

    // Back-pressure in SEND_LO with a stray byte
    TX_READY = 1'b0;
    send_byte(8'hC0);
    send_byte(8'h10);
    send_byte(8'h20);
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("bp_txv", {15'd0, TX_VALID}, 16'h0001);
      check("bp_txd", {8'h00, TX_DATA}, 16'h0030);
      RX_DATA  = 8'h77;
      RX_VALID = (i == 2);
      @(negedge CLK);
    end
    RX_VALID = 1'b0;
    check("bp_txd_end", {8'h00, TX_DATA}, 16'h0030);
    check("bp_a_kept", {8'h00, ALU_A}, 16'h0010);
    TX_READY = 1'b1;
    expect_tx(8'h30, "bp_lo");
    expect_tx(8'h00, "bp_hi");
    check("bp_busy", {15'd0, BUSY}, 16'h0000);

    // Asynchronous reset during ALU_WAIT
    alu_auto = 1'b0;
    send_byte(8'hC2);
    send_byte(8'h03);
    send_byte(8'h04);
    check("mid_en", {15'd0, ALU_EN}, 16'h0001);
    #2 RST = 1'b0;
    #1;
    check("mid_a", {8'h00, ALU_A}, 16'h0000);
    check("mid_b", {8'h00, ALU_B}, 16'h0000);
    check("mid_fun", {12'h000, ALU_FUN}, 16'h0000);
    check("mid_en0", {15'd0, ALU_EN}, 16'h0000);
    check("mid_busy", {15'd0, BUSY}, 16'h0000);
    check("mid_txv", {15'd0, TX_VALID}, 16'h0000);
    @(negedge CLK);
    RST = 1'b1;
    alu_auto = 1'b1;
    send_byte(8'hC4);
    send_byte(8'hF0);
    send_byte(8'h0F);
    check("and_fun", {12'h000, ALU_FUN}, 16'h0004);
    expect_tx(8'h00, "and_lo");
    expect_tx(8'h00, "and_hi");

    // ALU never answers
    alu_auto = 1'b0;
    send_byte(8'hC0);
    send_byte(8'h01);
    send_byte(8'h01);
`ifdef ALU_TIMEOUT_EN
    for (int k = 1; k < 15; k++) begin
      @(negedge CLK);
      check("to_err_early", {15'd0, ALU_ERR}, 16'h0000);
    end
    check("to_en_early", {15'd0, ALU_EN}, 16'h0001);
    @(negedge CLK);
    check("to_err", {15'd0, ALU_ERR}, 16'h0001);
    check("to_en", {15'd0, ALU_EN}, 16'h0000);
    check("to_txv", {15'd0, TX_VALID}, 16'h0000);
    check("to_busy", {15'd0, BUSY}, 16'h0000);
    @(negedge CLK);
    check("to_err_pulse", {15'd0, ALU_ERR}, 16'h0000);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
    end
    check("nto_en", {15'd0, ALU_EN}, 16'h0001);
    check("nto_err", {15'd0, ALU_ERR}, 16'h0000);
    check("nto_busy", {15'd0, BUSY}, 16'h0001);
    check("nto_txv", {15'd0, TX_VALID}, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
